// File: rtl/enc_frame_arb_pkg.sv
// Shared types and constants for the frame-granular encoder arbiter.
// The optional zero-pad recovery path is enabled by ENC_FRAME_ARB_PAD_EN.
package enc_frame_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_STREAM = 2'd1;
  localparam arb_state_t ST_PAD    = 2'd2;
  localparam arb_state_t ST_DRAIN  = 2'd3;

  localparam int MCU_SAMPLES       = 64;
  localparam int FRAME_MCUS        = 256;
  localparam int FRAME_SAMPLES_DEF = MCU_SAMPLES * FRAME_MCUS;
  localparam int SCNT_W            = $clog2(FRAME_SAMPLES_DEF);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/enc_frame_arb_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that did not win last time. Purely combinational.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_src
);

  assign gnt_valid = req0 | req1;
  assign gnt_src   = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/enc_frame_arb.sv
// Grants the shared JPEG encoder to one of two sources for a whole frame,
// then drains. Define ENC_FRAME_ARB_PAD_EN to zero-pad frames after a stall.
module enc_frame_arb
  import enc_frame_arb_pkg::*;
#(
  parameter int FRAME_SAMPLES  = FRAME_SAMPLES_DEF,
  parameter int DRAIN_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] enc_din,
  output logic       enc_din_valid,
  output logic       out_src,
  output logic       busy,
  output logic       frame_done,
  output logic       err_pad
);

  localparam int SW = $clog2(FRAME_SAMPLES);
  localparam int CW = $clog2(max2(DRAIN_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [SW-1:0] SCNT_LAST  = SW'(FRAME_SAMPLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
`ifdef ENC_FRAME_ARB_PAD_EN
  localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  arb_state_t    state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_src_q, out_src_d;
  logic          last_grant_q, last_grant_d;
  logic [7:0]    din_q, din_d;
  logic          din_valid_q, din_valid_d;
  logic          gnt_valid, gnt_src, accept;

  rr_arb2 u_rr_arb2 (
    .req0       (req0_valid),
    .req1       (req1_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_src    (gnt_src)
  );

  assign accept = (state_q == ST_STREAM) & (out_src_q ? req1_valid : req0_valid);

`ifdef ENC_FRAME_ARB_PAD_EN
  logic err_pad_q, err_pad_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    scnt_d       = scnt_q;
    cnt_d        = cnt_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    din_d        = din_q;
    din_valid_d  = 1'b0;
`ifdef ENC_FRAME_ARB_PAD_EN
    err_pad_d    = err_pad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          out_src_d    = gnt_src;
          last_grant_d = gnt_src;
          scnt_d       = '0;
          cnt_d        = '0;
          state_d      = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          din_d       = out_src_q ? req1_data : req0_data;
          din_valid_d = 1'b1;
          scnt_d      = scnt_q + 1'b1;
          cnt_d       = '0;
          if (scnt_q == SCNT_LAST) state_d = ST_DRAIN;
        end else begin
`ifdef ENC_FRAME_ARB_PAD_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == STALL_LAST) begin
            state_d   = ST_PAD;
            err_pad_d = 1'b1;
          end
`endif
        end
      end
`ifdef ENC_FRAME_ARB_PAD_EN
      ST_PAD: begin
        din_d       = 8'd0;
        din_valid_d = 1'b1;
        scnt_d      = scnt_q + 1'b1;
        cnt_d       = '0;
        if (scnt_q == SCNT_LAST) state_d = ST_DRAIN;
      end
`endif
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments, and reset is sampled
  // on the clock edge only, so a mid-frame reset lands on the next edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      scnt_q       <= '0;
      cnt_q        <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      din_q        <= 8'd0;
      din_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      cnt_q        <= cnt_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      din_q        <= din_d;
      din_valid_q  <= din_valid_d;
    end
  end

`ifdef ENC_FRAME_ARB_PAD_EN
  always_ff @(posedge clk) begin
    if (!nrst) err_pad_q <= 1'b0;
    else       err_pad_q <= err_pad_d;
  end
  assign err_pad = err_pad_q;
`else
  assign err_pad = 1'b0;
`endif

  assign req0_ready    = (state_q == ST_STREAM) & ~out_src_q;
  assign req1_ready    = (state_q == ST_STREAM) &  out_src_q;
  assign enc_din       = din_q;
  assign enc_din_valid = din_valid_q;
  assign out_src       = out_src_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = (state_q == ST_DRAIN) & (cnt_q == DRAIN_LAST);

endmodule
